// File: rtl/gcd_pkg.sv
// Shared types and defaults for the shared GCD scheduler and its datapath.
package gcd_pkg;

  // Scheduler FSM: wait for a request, iterate the remainder datapath, hold the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } sched_state_t;

  // Default operand/result width.
  localparam int DEFAULT_W = 5;

endpackage

// File: rtl/gcd_core.sv
// Euclid remainder datapath: holds A and B and performs one A % B step per cycle.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] number1,
  input  logic [W-1:0] number2,
  input  logic         step,
  output logic [W-1:0] A_out,
  output logic         B_zero
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;

  // Next operands: load wins over step; a step with B == 0 is ignored so the modulo never sees a zero divisor.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      a_d = number1;
      b_d = number2;
    end else if (step && (b_q != '0)) begin
      a_d = b_q;
      b_d = a_q % b_q;
    end
  end

  // Operand registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A_out  = a_q;
  assign B_zero = (b_q == '0);

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD remainder datapath among NREQ requesters.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEFAULT_W,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] number1_flat,
  input  logic [NREQ*W-1:0] number2_flat,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              done_valid,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      GSD,
  input  logic              done_ready
);

  // The guard forces a result after this many CALC cycles; Euclid on W-bit operands finishes well before it.
  localparam int GUARD_MAX = 2 * W + 2;
  localparam int GW        = $clog2(GUARD_MAX + 1);

  sched_state_t      state_q, state_d;
  logic [IDW-1:0]    rrPtr_q, rrPtr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              doneValid_q, doneValid_d;
  logic [W-1:0]      gsd_q, gsd_d;
  logic [GW-1:0]     guard_q, guard_d;

  logic [IDW-1:0]    win;
  logic              load;
  logic              step;
  logic [W-1:0]      opA;
  logic [W-1:0]      opB;
  logic [W-1:0]      aOut;
  logic              bZero;

  // First requester found scanning upward from the pointer, wrapping past NREQ-1.
  function automatic logic [IDW-1:0] rrSelect(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(p) + i) % NREQ;
      if (!found && r[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign win = rrSelect(req, rrPtr_q);
  assign opA = number1_flat[int'(win)*W +: W];
  assign opB = number2_flat[int'(win)*W +: W];

  gcd_core #(
    .W(W)
  ) u_core (
    .CLK    (CLK),
    .Reset  (Reset),
    .load   (load),
    .number1(opA),
    .number2(opB),
    .step   (step),
    .A_out  (aOut),
    .B_zero (bZero)
  );

  // Next-state logic: grant in IDLE, iterate in CALC, hold the result until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    id_d        = id_q;
    ack_d       = '0;
    busy_d      = busy_q;
    doneValid_d = doneValid_q;
    gsd_d       = gsd_q;
    guard_d     = guard_q;
    load        = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          id_d    = win;
          ack_d   = NREQ'(1) << win;
          busy_d  = 1'b1;
          guard_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bZero || (guard_q == GW'(GUARD_MAX - 1))) begin
          gsd_d       = aOut;
          doneValid_d = 1'b1;
          state_d     = RESULT;
        end else begin
          step    = 1'b1;
          guard_d = guard_q + GW'(1);
        end
      end
      RESULT: begin
        if (done_ready) begin
          doneValid_d = 1'b0;
          busy_d      = 1'b0;
          rrPtr_d     = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any job in flight without a response.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      doneValid_q <= 1'b0;
      gsd_q       <= '0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      id_q        <= id_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      doneValid_q <= doneValid_d;
      gsd_q       <= gsd_d;
      guard_q     <= guard_d;
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign done_valid = doneValid_q;
  assign done_id    = doneValid_q ? id_q : '0;
  assign GSD        = gsd_q;

endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
- Shares one sequential Euclid GCD datapath among NREQ requesters.
- Round-robin arbitration; one job in flight at a time.
- Latches the winner's operands and iterates the remainder datapath to completion.
- Returns the result with the requester ID over a valid/ready response port.
- Sits between the requesting blocks and the single GCD remainder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 5, operand and result width in bits.
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester job request; level, held until ack.
- number1_flat  input  NREQ*W  operand A per requester; slice i = bits [i*W +: W].
- number2_flat  input  NREQ*W  operand B per requester, same slicing.
- ack  output  NREQ  one-cycle, one-hot pulse: job accepted, operands captured.
- busy  output  1  high while a job occupies the datapath (CALC or RESULT).
- done_valid  output  1  result available.
- done_id  output  IDW  requester that owns the result.
- GSD  output  W  GCD result.
- done_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous, active-high, takes effect in any state.
  - All outputs 0; state IDLE; A, B, R = 0; rr_ptr = 0.
  - A job in flight is discarded with no response.
- FSM states: IDLE, CALC, RESULT.
- IDLE:
  - If req != 0, select the first set bit scanning from rr_ptr upward with wrap.
  - Latch A = number1[win], B = number2[win], id = win. Go to CALC.
  - ack[win] = 1 during the first CALC cycle only.
  - req is sampled only in IDLE. Dropping req after the grant cycle does not cancel the job.
- CALC (one iteration per cycle):
  - B == 0: go to RESULT with GSD = A.
  - Otherwise: A <= B; B <= A % B.
  - A < B needs no swap; the first iteration swaps naturally.
- RESULT:
  - done_valid = 1 with GSD and done_id held stable until done_ready = 1.
  - On handshake: rr_ptr = (id + 1) mod NREQ; go to IDLE. done_valid drops the next cycle.
  - A new grant can occur no earlier than the cycle after the handshake.
- Latency: from the grant edge to done_valid = 1 is 1 + k cycles, where k = number of nonzero-B iterations.
- Edge values:
  - GCD(a, 0) = a.
  - GCD(0, b) = b (one iteration).
  - GCD(0, 0) = 0.
- Width rules: all arithmetic is unsigned W-bit; the remainder never exceeds W bits.
- Iteration bound: k ≤ 8 for W = 5. An internal guard counter forces RESULT after 2*W+2 CALC cycles; this is unreachable for legal RTL.
- Simultaneous events: all req bits high → strict rotation 0, 1, 2, 3, 0, ...
- A requester with req set while its own job is in RESULT is re-eligible only after the pointer passes it.
- Outputs are registered; no combinational path from req to ack.

Decomposition:
- Package gcd_pkg holds:
  - state enum sched_state_t {IDLE, CALC, RESULT};
  - localparam default W.
- Sub-module gcd_core (the remainder datapath):
  - ports CLK, Reset, load, number1, number2, step, A_out, B_zero;
  - owns A/B registers and the A % B step.
- gcd_sched contains the arbiter, FSM, guard counter and response registers.
- Round-robin select is a function inside gcd_sched.

Test Plan:
- Reset mid-CALC: req[1] with (12, 8); assert Reset on the 2nd CALC cycle → all outputs 0 the same cycle; after release, no done_valid until a new request.
- Single job: req[0], (12, 8), done_ready = 1 → ack[0] one cycle later; done_valid 3 cycles after the grant edge with GSD = 4, done_id = 0.
- Edge operands:
  - (0, 0) → GSD = 0;
  - (21, 0) → GSD = 21, latency 1;
  - (0, 9) → GSD = 9;
  - (31, 30) → GSD = 1;
  - (8, 12) → GSD = 4.
- Fairness: req = 4'b1111, all four operand pairs (18, 12) → done_id sequence 0, 1, 2, 3, 0, each GSD = 6; exactly one ack per grant.
- Backpressure: done_ready = 0 for 5 cycles after done_valid → GSD and done_id stable, busy = 1, no new ack; ready = 1 → done_valid drops next cycle.
- Pointer wrap: requests only on 3 then 0 (held) → service order 3, 0. Then only req[1] → 1 is granted immediately.
